// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch constants and fetch-FSM state encoding.
// Pure declarations: no latency, no flow control.
package legv8_pkg;

    localparam logic [31:0] LEGV8_NOP = 32'hD503201F;
    localparam int unsigned PC_INC    = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/legv8_ifid_reg.sv
// IF/ID pipeline register: one-cycle load, flush beats hold, hold beats load.
// A cycle with nothing to load and no hold leaves a bubble (valid=0, NOP).
module legv8_ifid_reg #(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            load_vld,
    input  logic [PC_W-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            ifid_valid,
    output logic [PC_W-1:0] ifid_pc,
    output logic [31:0]     ifid_instr
);
    import legv8_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= LEGV8_NOP;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= LEGV8_NOP;
        end else if (!hold) begin
            if (load_vld) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= load_pc;
                ifid_instr <= load_instr;
            end else begin
                ifid_valid <= 1'b0;
                ifid_pc    <= '0;
                ifid_instr <= LEGV8_NOP;
            end
        end
    end

endmodule

// File: rtl/legv8_if_stage.sv
// LEGv8 fetch stage: PC, imem req/ack handshake, one-entry hold buffer, IF/ID load.
// Ack in cycle N shows in IF/ID after edge N+1; ID stall parks one fetch in the hold buffer.
module legv8_if_stage #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [PC_W-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [PC_W-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic [PC_W-1:0] pc
);
    import legv8_pkg::*;

    fetch_state_t    state;
    logic            hold_vld;
    logic [PC_W-1:0] hold_pc;
    logic [31:0]     hold_instr;

    logic            ack_take;
    logic            ifid_hold;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic            load_vld;
    logic [PC_W-1:0] load_pc;
    logic [31:0]     load_instr;

    assign ack_take  = imem_req & imem_ack;
    // An empty IF/ID can always accept, even while ID is stalling.
    assign ifid_hold = stall & ifid_valid;
    assign pc_inc    = pc + PC_W'(PC_INC);
    assign target    = branch_target & ~PC_W'(3);

    always_comb begin
        load_vld   = 1'b0;
        load_pc    = imem_addr;
        load_instr = imem_rdata;
        if (state == ST_REQ && ack_take) begin
            load_vld = 1'b1;
        end else if (state == ST_HOLD && hold_vld) begin
            load_vld   = 1'b1;
            load_pc    = hold_pc;
            load_instr = hold_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_req   <= 1'b0;
            hold_vld   <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= LEGV8_NOP;
        end else if (pc_src) begin
            pc       <= target;
            hold_vld <= 1'b0;
            unique case (state)
                ST_REQ, ST_DRAIN: begin
                    // Without an ack the old request must stay on the bus until it completes.
                    if (ack_take) begin
                        imem_addr <= target;
                        state     <= ST_REQ;
                    end else begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    imem_addr <= target;
                    imem_req  <= 1'b1;
                    state     <= ST_REQ;
                end
            endcase
        end else begin
            unique case (state)
                ST_BOOT: begin
                    imem_addr <= pc;
                    imem_req  <= 1'b1;
                    state     <= ST_REQ;
                end
                ST_REQ: begin
                    if (ack_take) begin
                        if (!ifid_hold) begin
                            pc        <= pc_inc;
                            imem_addr <= pc_inc;
                        end else begin
                            hold_vld   <= 1'b1;
                            hold_pc    <= imem_addr;
                            hold_instr <= imem_rdata;
                            imem_req   <= 1'b0;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        hold_vld  <= 1'b0;
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        imem_req  <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (ack_take) begin
                        imem_addr <= pc;
                        state     <= ST_REQ;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= ST_BOOT;
                end
            endcase
        end
    end

    legv8_ifid_reg #(
        .PC_W (PC_W)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .flush      (pc_src),
        .hold       (ifid_hold),
        .load_vld   (load_vld),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr)
    );

endmodule

// File: tb/tb_legv8_if_stage.sv
// Directed bench for legv8_if_stage: boot, stall/hold, drain, flush-over-stall, PC wrap, async reset.
module tb_legv8_if_stage;
    import legv8_pkg::*;

    localparam int              PC_W    = 64;
    localparam logic [PC_W-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic            clk = 1'b0;
    logic            rst;
    logic            pc_src;
    logic [PC_W-1:0] branch_target;
    logic            stall;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            ifid_valid;
    logic [PC_W-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic [PC_W-1:0] pc;

    logic            w_pc_src;
    logic [PC_W-1:0] w_target;
    logic            w_stall;
    logic            w_req;
    logic [PC_W-1:0] w_addr;
    logic            w_ack;
    logic [31:0]     w_rdata;
    logic            w_ifid_valid;
    logic [PC_W-1:0] w_ifid_pc;
    logic [31:0]     w_ifid_instr;
    logic [PC_W-1:0] w_pc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    legv8_if_stage #(.PC_W(PC_W), .RESET_PC('0)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .pc            (pc)
    );

    legv8_if_stage #(.PC_W(PC_W), .RESET_PC(WRAP_PC)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (w_pc_src),
        .branch_target (w_target),
        .stall         (w_stall),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (w_ack),
        .imem_rdata    (w_rdata),
        .ifid_valid    (w_ifid_valid),
        .ifid_pc       (w_ifid_pc),
        .ifid_instr    (w_ifid_instr),
        .pc            (w_pc)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_src = 1'b0; branch_target = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        w_pc_src = 1'b0; w_target = '0; w_stall = 1'b0;
        w_ack = 1'b1; w_rdata = 32'hC0DE_0001;

        #2;
        chk("rst_req",   64'(imem_req),   64'd0);
        chk("rst_addr",  imem_addr,       64'd0);
        chk("rst_valid", 64'(ifid_valid), 64'd0);
        chk("rst_ifpc",  ifid_pc,         64'd0);
        chk("rst_instr", 64'(ifid_instr), 64'(LEGV8_NOP));
        chk("rst_pc",    pc,              64'd0);
        chk("w_rst_pc",  w_pc,            WRAP_PC);

        // Test 1: boot then back-to-back fetch
        @(negedge clk); rst = 1'b0; #1;
        chk("boot_req",   64'(imem_req), 64'd0);
        chk("w_boot_req", 64'(w_req),    64'd0);
        tick();
        chk("req0",      64'(imem_req), 64'd1);
        chk("addr0",     imem_addr,     64'd0);
        chk("w_addr0",   w_addr,        WRAP_PC);
        imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
        tick();
        chk("f0_valid",  64'(ifid_valid), 64'd1);
        chk("f0_pc",     ifid_pc,         64'd0);
        chk("f0_instr",  64'(ifid_instr), 64'hA000_0000);
        chk("addr4",     imem_addr,       64'd4);
        chk("w_addr1",   w_addr,          64'd0);
        chk("w_ifpc0",   w_ifid_pc,       WRAP_PC);
        imem_rdata = 32'hA000_0001;
        tick();
        chk("f1_pc",     ifid_pc,         64'd4);
        chk("f1_instr",  64'(ifid_instr), 64'hA000_0001);
        chk("addr8",     imem_addr,       64'd8);
        imem_rdata = 32'hA000_0002;
        tick();
        chk("f2_pc",     ifid_pc,         64'd8);
        chk("f2_instr",  64'(ifid_instr), 64'hA000_0002);
        chk("pc12",      pc,              64'd12);

        // Test 2: stall with IF/ID full parks the fetch in the hold buffer
        stall = 1'b1; imem_rdata = 32'hA000_0003;
        tick();
        chk("hold_req",   64'(imem_req),   64'd0);
        chk("hold_ifpc",  ifid_pc,         64'd8);
        chk("hold_instr", 64'(ifid_instr), 64'hA000_0002);
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("hold2_req",  64'(imem_req),   64'd0);
        chk("hold2_ifpc", ifid_pc,         64'd8);
        stall = 1'b0; imem_ack = 1'b0;
        tick();
        chk("rel_valid", 64'(ifid_valid), 64'd1);
        chk("rel_pc",    ifid_pc,         64'd12);
        chk("rel_instr", 64'(ifid_instr), 64'hA000_0003);
        chk("rel_addr",  imem_addr,       64'd16);
        chk("rel_req",   64'(imem_req),   64'd1);

        // Test 3: redirect with request outstanding -> drain
        pc_src = 1'b1; branch_target = 64'h103;
        tick();
        chk("drn_req",   64'(imem_req),   64'd1);
        chk("drn_addr",  imem_addr,       64'd16);
        chk("drn_pc",    pc,              64'h100);
        chk("drn_valid", 64'(ifid_valid), 64'd0);
        pc_src = 1'b0;
        tick();
        chk("drn2_addr", imem_addr,       64'd16);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("tgt_addr",  imem_addr,       64'h100);
        chk("tgt_valid", 64'(ifid_valid), 64'd0);
        chk("tgt_instr", 64'(ifid_instr), 64'(LEGV8_NOP));
        imem_rdata = 32'hA000_0004;
        tick();
        chk("t0_pc",     ifid_pc,         64'h100);
        chk("t0_instr",  64'(ifid_instr), 64'hA000_0004);
        chk("t0_addr",   imem_addr,       64'h104);

        // Test 4: redirect + ack + stall in one cycle flushes IF/ID
        stall = 1'b1; pc_src = 1'b1; branch_target = 64'h200; imem_rdata = 32'hBAD0_BAD0;
        tick();
        chk("fl_valid",  64'(ifid_valid), 64'd0);
        chk("fl_instr",  64'(ifid_instr), 64'(LEGV8_NOP));
        chk("fl_addr",   imem_addr,       64'h200);
        chk("fl_req",    64'(imem_req),   64'd1);
        stall = 1'b0; pc_src = 1'b0; imem_rdata = 32'hA000_0005;
        tick();
        chk("b0_pc",     ifid_pc,         64'h200);
        chk("b0_instr",  64'(ifid_instr), 64'hA000_0005);
        chk("b0_addr",   imem_addr,       64'h204);

        // Test 6: asynchronous reset mid-request
        imem_ack = 1'b0;
        #2; rst = 1'b1; #1;
        chk("ar_req",   64'(imem_req),   64'd0);
        chk("ar_addr",  imem_addr,       64'd0);
        chk("ar_valid", 64'(ifid_valid), 64'd0);
        chk("ar_ifpc",  ifid_pc,         64'd0);
        chk("ar_instr", 64'(ifid_instr), 64'(LEGV8_NOP));
        chk("ar_pc",    pc,              64'd0);
        chk("w_ar_addr", w_addr,         WRAP_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
